// File: rtl/spi_sclk_ctrl.sv
// SPI serial-clock sequencer: divides CLK by a runtime half-period and emits NUM_BITS SCLK periods per START.
// Optional macro SPI_SCLK_STALL_EN adds the STALL port that freezes the divider during a burst.
module spi_sclk_ctrl #(
  parameter int unsigned DIV_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] FACTOR,
  input  logic [CNT_W-1:0] NUM_BITS,
  input  logic             CPOL,
  input  logic             START,
  input  logic             ABORT,
`ifdef SPI_SCLK_STALL_EN
  input  logic             STALL,
`endif
  output logic             SCLK,
  output logic             LEAD_EDGE,
  output logic             TRAIL_EDGE,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [CNT_W:0]   tog_q, tog_d;
  logic             cpol_q, cpol_d;
  logic             sclk_q, sclk_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             stall;
  logic             start_ok;
  logic             tick;
  logic             last;
  logic [DIV_W-1:0] fm1;

`ifdef SPI_SCLK_STALL_EN
  assign stall = STALL;
`else
  assign stall = 1'b0;
`endif

  // A START landing in the DONE cycle is dropped rather than queued.
  assign start_ok = START && !done_q;
  assign tick     = (half_q == '0) && !stall;
  assign last     = (tog_q == (CNT_W+1)'(1));
  assign fm1      = (FACTOR == '0) ? '0 : FACTOR - DIV_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      half_q   <= '0;
      reload_q <= '0;
      tog_q    <= '0;
      cpol_q   <= 1'b0;
      sclk_q   <= 1'b0;
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      reload_q <= reload_d;
      tog_q    <= tog_d;
      cpol_q   <= cpol_d;
      sclk_q   <= sclk_d;
      lead_q   <= lead_d;
      trail_q  <= trail_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_ok && (NUM_BITS != '0)) state_d = S_RUN;
      S_RUN:  if (ABORT || (tick && last))      state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    half_d   = half_q;
    reload_d = reload_q;
    tog_d    = tog_q;
    cpol_d   = cpol_q;
    sclk_d   = sclk_q;
    lead_d   = 1'b0;
    trail_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          cpol_d = CPOL;
          sclk_d = CPOL;
          if (NUM_BITS != '0) begin
            busy_d   = 1'b1;
            half_d   = fm1;
            reload_d = fm1;
            tog_d    = {NUM_BITS, 1'b0};
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (ABORT) begin
          sclk_d = cpol_q;
          busy_d = 1'b0;
        end else if (!stall) begin
          if (tick) begin
            sclk_d = ~sclk_q;
            half_d = reload_q;
            tog_d  = tog_q - (CNT_W+1)'(1);
            // Remaining count even before a toggle means it is an odd-numbered (leading) toggle.
            if (!tog_q[0]) begin
              lead_d = 1'b1;
            end else begin
              trail_d = 1'b1;
            end
            if (last) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end else begin
            half_d = half_q - DIV_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign SCLK       = sclk_q;
  assign LEAD_EDGE  = lead_q;
  assign TRAIL_EDGE = trail_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_spi_sclk_ctrl.sv
// Scoreboard bench for spi_sclk_ctrl: per-edge expected outputs are queued as stimulus is driven.
// Build with SPI_SCLK_STALL_EN defined to include the stall scenario.
module tb_spi_sclk_ctrl;
  localparam int unsigned DIV_W = 32;
  localparam int unsigned CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [DIV_W-1:0] FACTOR = '0;
  logic [CNT_W-1:0] NUM_BITS = '0;
  logic             CPOL = 1'b0;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic             STALL = 1'b0;
  logic             SCLK, LEAD_EDGE, TRAIL_EDGE, BUSY, DONE;

  typedef struct packed {
    logic sclk;
    logic lead;
    logic trail;
    logic busy;
    logic done;
  } exp_t;

  exp_t sb[$];
  exp_t act;
  int   n_cmp  = 0;
  int   n_fail = 0;

  assign act = {SCLK, LEAD_EDGE, TRAIL_EDGE, BUSY, DONE};

  always #5 CLK = ~CLK;

  spi_sclk_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FACTOR     (FACTOR),
    .NUM_BITS   (NUM_BITS),
    .CPOL       (CPOL),
    .START      (START),
    .ABORT      (ABORT),
`ifdef SPI_SCLK_STALL_EN
    .STALL      (STALL),
`endif
    .SCLK       (SCLK),
    .LEAD_EDGE  (LEAD_EDGE),
    .TRAIL_EDGE (TRAIL_EDGE),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  // Outputs at edge k+r of an uninterrupted burst accepted at edge k: toggles at r = n*fp, n = 1..2n.
  function automatic exp_t burst_exp(int r, int fp, int n, logic cpol);
    exp_t e;
    int   t;
    e = '0;
    if (n == 0) begin
      e.sclk = cpol;
      e.done = (r == 0);
      return e;
    end
    t = r / fp;
    if (t > 2 * n) t = 2 * n;
    e.sclk = cpol ^ t[0];
    e.busy = (r < 2 * n * fp);
    if (r > 0 && (r % fp) == 0 && (r / fp) <= 2 * n) begin
      if ((r / fp) % 2 == 1) e.lead = 1'b1;
      else                   e.trail = 1'b1;
    end
    e.done = (r == 2 * n * fp);
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    RST = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sb.push_back('0);
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL reset r=%0d: got %b expected %b", r, act, e);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    FACTOR = 3; NUM_BITS = 2; CPOL = 1'b0;
    for (int r = 0; r < 16; r++) begin
      START = (r == 0);
      sb.push_back(burst_exp(r, 3, 2, 1'b0));
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL basic r=%0d: got %b expected %b", r, act, e);
      end
    end
    START = 1'b0;
  endtask

  task automatic test_factor_zero();
    exp_t e;
    FACTOR = 0; NUM_BITS = 1; CPOL = 1'b1;
    for (int r = 0; r < 5; r++) begin
      START = (r == 0);
      sb.push_back(burst_exp(r, 1, 1, 1'b1));
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL factor_zero r=%0d: got %b expected %b", r, act, e);
      end
    end
    START = 1'b0;
  endtask

  task automatic test_zero_bits();
    exp_t e, x;
    FACTOR = 5; NUM_BITS = 0; CPOL = 1'b1;
    for (int r = 0; r < 10; r++) begin
      START = (r == 5) || (r == 6);
      if (r == 6) NUM_BITS = 2;
      x = '0;
      x.sclk = 1'b1;
      x.done = (r == 5);
      sb.push_back(x);
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL zero_bits r=%0d: got %b expected %b", r, act, e);
      end
    end
    START = 1'b0; NUM_BITS = 0;
  endtask

  task automatic test_busy_abort();
    exp_t e;
    FACTOR = 4; NUM_BITS = 3; CPOL = 1'b0;
    for (int r = 0; r < 16; r++) begin
      START = (r == 0) || (r == 6);
      if (r == 6) begin
        FACTOR = 1; NUM_BITS = 1; CPOL = 1'b1;
      end
      ABORT = (r == 11);
      sb.push_back((r <= 10) ? burst_exp(r, 4, 3, 1'b0) : exp_t'('0));
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL busy_abort r=%0d: got %b expected %b", r, act, e);
      end
    end
    START = 1'b0; ABORT = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    FACTOR = 2; NUM_BITS = 4; CPOL = 1'b1;
    for (int r = 0; r < 30; r++) begin
      START = (r == 0) || (r == 9);
      RST   = (r == 8);
      if (r < 8)       sb.push_back(burst_exp(r, 2, 4, 1'b1));
      else if (r == 8) sb.push_back('0);
      else             sb.push_back(burst_exp(r - 9, 2, 4, 1'b1));
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL reset_mid r=%0d: got %b expected %b", r, act, e);
      end
    end
    START = 1'b0; RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    FACTOR = 1; NUM_BITS = 1; CPOL = 1'b0;
    for (int r = 0; r < 10; r++) begin
      START = (r <= 4);
      ABORT = (r == 0);
      sb.push_back((r < 4) ? burst_exp(r, 1, 1, 1'b0) : burst_exp(r - 4, 1, 1, 1'b0));
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL back_to_back r=%0d: got %b expected %b", r, act, e);
      end
    end
    START = 1'b0; ABORT = 1'b0;
  endtask

`ifdef SPI_SCLK_STALL_EN
  task automatic test_stall();
    exp_t e, x;
    FACTOR = 2; NUM_BITS = 1; CPOL = 1'b0;
    for (int r = 0; r < 10; r++) begin
      START = (r == 0);
      STALL = (r >= 2) && (r <= 4);
      x = '0;
      x.sclk  = (r >= 5) && (r < 7);
      x.lead  = (r == 5);
      x.trail = (r == 7);
      x.done  = (r == 7);
      x.busy  = (r < 7);
      sb.push_back(x);
      @(posedge CLK); #1;
      e = sb.pop_front(); n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL stall r=%0d: got %b expected %b", r, act, e);
      end
    end
    START = 1'b0; STALL = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_factor_zero();
    test_zero_bits();
    test_busy_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef SPI_SCLK_STALL_EN
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
